// File: rtl/branch_predictor_bht_pkg.sv
// Shared pipeline definitions for the branch predictor.
//   PC_W    : program counter width
//   PC_INC  : sequential fetch increment
//   ctr_e   : 2-bit saturating counter encodings; bit 1 is the taken prediction
//   next_seq_pc() : fall-through PC, wraps at 2**32
package branch_predictor_bht_pkg;

  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  function automatic logic [PC_W-1:0] next_seq_pc(input logic [PC_W-1:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/branch_predictor_bht_sat.sv
// 2-bit saturating up/down counter, next-state only (no storage).
//   ctr      in  2  current counter value
//   inc      in  1  1 = count toward strongly taken, 0 = toward strongly not-taken
//   ctr_next out 2  saturated next value
module sat_counter2
  import branch_predictor_bht_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       inc,
  output logic [1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (inc) begin
      if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor_bht.sv
// Direct-mapped BHT+BTB branch predictor with misprediction detection and
// statistics counters.
//   clk, rst_n          : clock, synchronous active-low reset
//   if_pc               : fetch PC looked up combinationally
//   predict/pred_target : prediction for if_pc (target = if_pc+4 on miss)
//   ex_*                : branch resolution from EX, including the prediction
//                         that was carried down the pipe with it
//   mispredict          : comb. flush request, redirect_pc is the correct next PC
//   stat_branches       : resolved conditional branches (wraps)
//   stat_mispred        : mispredicted branches (wraps)
// Handshake: there is no back-pressure; an EX resolution is consumed on the
// clock edge at which ex_valid && ex_is_branch is high with rst_n high.
module branch_predictor_bht
  import branch_predictor_bht_pkg::*;
#(
  parameter int         IDX_W    = 6,
  parameter logic [1:0] INIT_CTR = 2'b10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  output logic        predict,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispred
);

  localparam int ENTRIES = 2 ** IDX_W;
  localparam int TAG_W   = PC_W - IDX_W - 2;

  // valid is a flat vector so reset clears every entry in one cycle; the
  // payload arrays carry no reset and are only meaningful behind valid.
  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [PC_W-1:0]    target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             if_hit, ex_hit, upd;
  logic [1:0]       ctr_next;

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[PC_W-1:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[PC_W-1:IDX_W+2];

  // Lookup sees pre-update table contents; a same-cycle write to the same
  // index only becomes visible after the edge.
  assign if_hit      = rst_n && valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign predict     = if_hit && ctr_q[if_idx][1];
  assign pred_target = if_hit ? target_q[if_idx] : next_seq_pc(if_pc);

  assign upd    = ex_valid && ex_is_branch && rst_n;
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  // A taken branch is also wrong if it was predicted taken to a stale target.
  assign mispredict  = upd && ((ex_taken != ex_pred_taken) ||
                               (ex_taken && (ex_target != ex_pred_target)));
  assign redirect_pc = ex_taken ? ex_target : next_seq_pc(ex_pc);

  sat_counter2 u_ctr (
    .ctr      (ctr_q[ex_idx]),
    .inc      (ex_taken),
    .ctr_next (ctr_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q       <= '0;
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else if (upd) begin
      stat_branches <= stat_branches + 32'd1;
      if (mispredict) stat_mispred <= stat_mispred + 32'd1;
      if (!ex_hit && ex_taken) valid_q[ex_idx] <= 1'b1;
    end
  end

  // Payload writes; upd already excludes reset, so reset wins over an update.
  always_ff @(posedge clk) begin
    if (upd) begin
      if (ex_hit) begin
        ctr_q[ex_idx] <= ctr_next;
        if (ex_taken) target_q[ex_idx] <= ex_target;
      end else if (ex_taken) begin
        // Allocation overwrites whatever aliased entry lived at this index.
        tag_q[ex_idx]    <= ex_tag;
        target_q[ex_idx] <= ex_target;
        ctr_q[ex_idx]    <= INIT_CTR;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor_bht.sv
module tb_branch_predictor_bht;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        predict;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic        ex_is_branch;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;

  int tests_run;
  int tests_failed;

  branch_predictor_bht dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_pc          (if_pc),
    .predict        (predict),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc),
    .stat_branches  (stat_branches),
    .stat_mispred   (stat_mispred)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // Inputs change on the falling edge; comb. outputs are checked 1ns later,
  // well before the next rising edge that commits the update.
  task automatic drive_idle(input logic [31:0] pc);
    @(negedge clk);
    if_pc          = pc;
    ex_valid       = 1'b0;
    ex_is_branch   = 1'b0;
    ex_pc          = 32'h0;
    ex_taken       = 1'b0;
    ex_target      = 32'h0;
    ex_pred_taken  = 1'b0;
    ex_pred_target = 32'h0;
    #1;
  endtask

  task automatic drive_ex(input logic [31:0] fpc, input logic [31:0] pc,
                          input logic tk, input logic [31:0] tgt,
                          input logic ptk, input logic [31:0] ptgt);
    @(negedge clk);
    if_pc          = fpc;
    ex_valid       = 1'b1;
    ex_is_branch   = 1'b1;
    ex_pc          = pc;
    ex_taken       = tk;
    ex_target      = tgt;
    ex_pred_taken  = ptk;
    ex_pred_target = ptgt;
    #1;
  endtask

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n          = 1'b0;
    if_pc          = 32'h40;
    ex_valid       = 1'b0;
    ex_is_branch   = 1'b0;
    ex_pc          = 32'h0;
    ex_taken       = 1'b0;
    ex_target      = 32'h0;
    ex_pred_taken  = 1'b0;
    ex_pred_target = 32'h0;

    // 1: reset
    repeat (2) @(posedge clk);
    drive_idle(32'h40);
    check("rst_predict", {31'b0, predict}, 32'd0);
    check("rst_ptgt", pred_target, 32'h44);
    check("rst_mispred_out", {31'b0, mispredict}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_stat_br", stat_branches, 32'd0);
    check("rst_stat_mp", stat_mispred, 32'd0);
    check("rst_lookup_miss", {31'b0, predict}, 32'd0);
    check("rst_lookup_ptgt", pred_target, 32'h44);

    // 2: first taken branch allocates
    drive_ex(32'h40, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
    check("alloc_mispredict", {31'b0, mispredict}, 32'd1);
    check("alloc_redirect", redirect_pc, 32'h100);
    drive_idle(32'h40);
    check("alloc_stat_mp", stat_mispred, 32'd1);
    check("alloc_stat_br", stat_branches, 32'd1);
    check("alloc_predict", {31'b0, predict}, 32'd1);
    check("alloc_ptgt", pred_target, 32'h100);

    // 3: saturate to 11, then two not-taken
    drive_ex(32'h40, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
    check("sat_correct", {31'b0, mispredict}, 32'd0);
    drive_ex(32'h40, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
    drive_ex(32'h40, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
    drive_ex(32'h40, 32'h40, 1'b0, 32'h100, 1'b1, 32'h100);
    check("nt1_mispredict", {31'b0, mispredict}, 32'd1);
    check("nt1_redirect", redirect_pc, 32'h44);
    drive_idle(32'h40);
    check("nt1_predict", {31'b0, predict}, 32'd1);
    check("sat_stat_br", stat_branches, 32'd5);
    drive_ex(32'h40, 32'h40, 1'b0, 32'h100, 1'b1, 32'h100);
    drive_idle(32'h40);
    check("nt2_predict", {31'b0, predict}, 32'd0);
    check("nt2_ptgt_hit", pred_target, 32'h100);
    check("nt2_stat_br", stat_branches, 32'd6);
    check("nt2_stat_mp", stat_mispred, 32'd3);

    // 4: alias at same index overwrites
    drive_ex(32'h140, 32'h140, 1'b1, 32'h200, 1'b0, 32'h144);
    check("alias_mispredict", {31'b0, mispredict}, 32'd1);
    drive_idle(32'h40);
    check("alias_old_miss", {31'b0, predict}, 32'd0);
    check("alias_old_ptgt", pred_target, 32'h44);
    drive_idle(32'h140);
    check("alias_new_hit", {31'b0, predict}, 32'd1);
    check("alias_new_ptgt", pred_target, 32'h200);

    // 5: same-cycle lookup/allocate, target mismatch
    drive_ex(32'h80, 32'h80, 1'b1, 32'h104, 1'b1, 32'h100);
    check("same_predict_pre", {31'b0, predict}, 32'd0);
    check("tgt_mispredict", {31'b0, mispredict}, 32'd1);
    check("tgt_redirect", redirect_pc, 32'h104);
    drive_idle(32'h80);
    check("same_predict_post", {31'b0, predict}, 32'd1);
    check("same_ptgt_post", pred_target, 32'h104);
    check("same_stat_br", stat_branches, 32'd8);
    check("same_stat_mp", stat_mispred, 32'd5);

    // not-taken miss: correct prediction, no allocation
    drive_ex(32'hC0, 32'hC0, 1'b0, 32'h500, 1'b0, 32'hC4);
    check("ntmiss_mispredict", {31'b0, mispredict}, 32'd0);
    drive_idle(32'hC0);
    check("ntmiss_no_alloc", {31'b0, predict}, 32'd0);
    // fall-through redirect wraps at 2**32
    drive_ex(32'h0, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h10);
    check("wrap_mispredict", {31'b0, mispredict}, 32'd1);
    check("wrap_redirect", redirect_pc, 32'h0);
    drive_idle(32'h0);
    check("wrap_stat_br", stat_branches, 32'd10);
    check("wrap_stat_mp", stat_mispred, 32'd6);

    // 6: non-branch and invalid EX slots change nothing
    drive_ex(32'h180, 32'h180, 1'b1, 32'h300, 1'b0, 32'h184);
    ex_is_branch = 1'b0;
    #1;
    check("nonbr_mispredict", {31'b0, mispredict}, 32'd0);
    drive_ex(32'h180, 32'h180, 1'b1, 32'h300, 1'b0, 32'h184);
    ex_valid = 1'b0;
    #1;
    check("inval_mispredict", {31'b0, mispredict}, 32'd0);
    drive_idle(32'h180);
    check("nonbr_no_alloc", {31'b0, predict}, 32'd0);
    check("nonbr_stat_br", stat_branches, 32'd10);
    check("nonbr_stat_mp", stat_mispred, 32'd6);

    // reset during an update: reset wins
    drive_ex(32'h180, 32'h180, 1'b1, 32'h300, 1'b0, 32'h184);
    rst_n = 1'b0;
    #1;
    check("rstupd_mispredict", {31'b0, mispredict}, 32'd0);
    check("rstupd_ptgt", pred_target, 32'h184);
    @(negedge clk);
    rst_n = 1'b1;
    ex_valid = 1'b0;
    ex_is_branch = 1'b0;
    #1;
    check("rstupd_stat_br", stat_branches, 32'd0);
    check("rstupd_stat_mp", stat_mispred, 32'd0);
    check("rstupd_no_write", {31'b0, predict}, 32'd0);
    drive_idle(32'h80);
    check("rstupd_valid_clr", {31'b0, predict}, 32'd0);
    check("rstupd_valid_ptgt", pred_target, 32'h84);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
